// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------
// dmem_mmio
//
// Data-memory stage for the single-cycle core. Every access finishes in one
// cycle: stores commit on the rising clock edge and loads are combinational
// from addr. Back-pressure is reported through STATUS bits only, never
// through wait states.
//
// Address map:
//   addr[31] = 0 : word RAM, index addr[AW+1:2]. All other address bits are
//                  ignored, so out-of-range addresses wrap onto the RAM.
//   addr[31] = 1 : MMIO page, decoded on addr[3:2] only
//                  0 TXDATA  write pushes writedata[7:0], read returns 0
//                  1 STATUS  {16'b0, count[7:0], 4'b0, overflow, empty, full,
//                            1'b0}; any write clears overflow
//                  2 CYCLE   free-running cycle counter, write loads it
//                  3 unused  reads 0, writes ignored
//
// Optional feature macro: DMEM_MMIO_CYCLE_CNT_EN
//   defined   : the 32-bit cycle counter exists.
//   undefined : no counter register; CYCLE reads 0 and CYCLE writes are
//               ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (FIFO state, overflow, counter;
//              RAM contents are kept)
//   memwrite   store strobe from the core
//   addr       byte address (core ALU result)
//   writedata  store data
//   readdata   load data, combinational from addr
//   tx_data    head byte of the transmit FIFO
//   tx_valid   transmit FIFO is non-empty
//   tx_ready   consumer accepts the head byte this cycle
//
// Drain handshake: a byte is transferred on a rising edge where both
// tx_valid and tx_ready are 1. While tx_valid=1 and tx_ready=0 the head byte
// (tx_data) is held stable. tx_valid never depends on tx_ready. tx_data is
// meaningless while tx_valid=0.
// ---------------------------------------------------------------------------
module dmem_mmio #(
    parameter int MEM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          sel_ram;
    logic          sel_mmio;
    logic [1:0]    mmio_reg;
    logic [AW-1:0] ram_idx;

    assign sel_ram  = ~addr[31];
    assign sel_mmio = addr[31];
    assign mmio_reg = addr[3:2];
    assign ram_idx  = addr[AW+1:2];

    // Bits that play no part in decoding; folded together only to show
    // they are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[30:AW+2], addr[1:0]};

    logic ram_we;
    logic push;
    logic status_wr;

    assign ram_we    = memwrite & sel_ram;
    assign push      = memwrite & sel_mmio & (mmio_reg == REG_TXDATA);
    assign status_wr = memwrite & sel_mmio & (mmio_reg == REG_STATUS);

    // ------------------------------------------------------------------
    // Word RAM: zero at time 0, untouched by reset, full-word writes only.
    // The read is asynchronous, so a load in the same cycle as a store to
    // the same word still sees the old contents.
    // ------------------------------------------------------------------
    logic [31:0] ram [MEM_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic full;
    logic empty;
    logic pop;
    logic push_ok;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    // When full, a push still fits if the head leaves on the same edge. In
    // that case wr_ptr equals rd_ptr, and the slot being overwritten is the
    // one being popped, so the head byte is consumed before it is replaced.
    assign push_ok  = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte takes priority over a clearing STATUS write.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (status_wr) begin
                overflow <= 1'b0;
            end
        end
    end

    logic [31:0] status_word;
    assign status_word = {16'b0, 8'(count), 4'b0, overflow, empty, full, 1'b0};

    // ------------------------------------------------------------------
    // Cycle counter (optional)
    // ------------------------------------------------------------------
    logic [31:0] cycle_rd;

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic        cycle_wr;
    logic [31:0] cycle_cnt;

    assign cycle_wr = memwrite & sel_mmio & (mmio_reg == REG_CYCLE);

    // A software load replaces the increment on that edge, so the value
    // written is exactly what the next cycle reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (cycle_wr) begin
            cycle_cnt <= writedata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cycle_rd = cycle_cnt;
`else
    assign cycle_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        if (sel_ram) begin
            readdata = ram[ram_idx];
        end else begin
            case (mmio_reg)
                REG_STATUS: readdata = status_word;
                REG_CYCLE:  readdata = cycle_rd;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// ---------------------------------------------------------------------------
// tb_dmem_mmio
//
// Directed bench for dmem_mmio: RAM store/load and aliasing, FIFO fill and
// drain, overflow, full push-with-pop, empty push-with-ready, MMIO decode,
// cycle counter (both macro builds) and reset during a drain.
// Inputs change at posedge+1; outputs are sampled at least 1 time unit
// after that, away from the active edge.
// ---------------------------------------------------------------------------
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;
    logic [31:0] rd;

    localparam logic [31:0] A_TXDATA = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_REG3   = 32'h8000_001C;

    dmem_mmio #(.MEM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        write_word(A_TXDATA, {24'h0, b});
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = readdata;
    endtask

    // Drains whatever the scoreboard expects, one byte per cycle.
    task automatic drain_and_check(input string tag);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                bad++;
                $display("FAIL %s_drain: valid=%b data=%h, required valid=1 data=%h",
                         tag, tx_valid, tx_data, exp_b);
            end
            step();
        end
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_empty_after: valid=%b, required 0", tag, tx_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b, required 0", tx_valid);
        end
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0004) begin
            bad++; $display("FAIL reset_status: got %h, required 00000004", rd);
        end
        read_word(A_CYCLE, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL reset_cycle: got %h, required 00000000", rd);
        end
        read_word(32'h0000_0020, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL ram_zero_init: got %h, required 00000000", rd);
        end
        read_word(A_TXDATA, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL txdata_read: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_ram();
        write_word(32'h0000_0010, 32'hDEAD_BEEF);
        read_word(32'h0000_0010, rd);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL ram_load: got %h, required deadbeef", rd);
        end
        read_word(32'h0000_0110, rd);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL ram_alias: got %h, required deadbeef", rd);
        end
        // Store and load the same word in one cycle: old value visible.
        addr      = 32'h0000_0010;
        writedata = 32'h1234_5678;
        memwrite  = 1'b1;
        #1;
        total++;
        if (readdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL ram_same_cycle: got %h, required deadbeef", readdata);
        end
        step();
        memwrite = 1'b0;
        read_word(32'h4000_0013, rd);
        total++;
        if (rd !== 32'h1234_5678) begin
            bad++; $display("FAIL ram_new_value: got %h, required 12345678", rd);
        end
        // Register 3 write must not reach RAM word 7.
        write_word(A_REG3, 32'hFFFF_FFFF);
        read_word(A_REG3, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL reg3_read: got %h, required 00000000", rd);
        end
        read_word(32'h0000_001C, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL reg3_no_ram: got %h, required 00000000", rd);
        end
    endtask

    task automatic test_fifo_fill_drain();
        tx_ready = 1'b0;
        push_byte(8'h41); exp_q.push_back(8'h41);
        push_byte(8'h42); exp_q.push_back(8'h42);
        push_byte(8'h43); exp_q.push_back(8'h43);
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0300) begin
            bad++; $display("FAIL fill_status: got %h, required 00000300", rd);
        end
        step();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            bad++; $display("FAIL fill_head_hold: valid=%b data=%h, required 1/41", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        drain_and_check("fill");
        tx_ready = 1'b0;
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0004) begin
            bad++; $display("FAIL drained_status: got %h, required 00000004", rd);
        end
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            push_byte(8'(i));
            if (i <= 8) exp_q.push_back(8'(i));
        end
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_080A) begin
            bad++; $display("FAIL ovf_status: got %h, required 0000080a", rd);
        end
        write_word(A_STATUS, 32'h0);
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0802) begin
            bad++; $display("FAIL ovf_clear: got %h, required 00000802", rd);
        end
        tx_ready = 1'b1;
        drain_and_check("ovf");
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_byte(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0802) begin
            bad++; $display("FAIL full_status: got %h, required 00000802", rd);
        end
        // Push 0x5A while the head 0x10 leaves.
        tx_ready  = 1'b1;
        addr      = A_TXDATA;
        writedata = 32'h0000_005A;
        memwrite  = 1'b1;
        #1;
        exp_b = exp_q.pop_front();
        total++;
        if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
            bad++; $display("FAIL full_pp_head: valid=%b data=%h, required 1/%h", tx_valid, tx_data, exp_b);
        end
        step();
        memwrite = 1'b0;
        exp_q.push_back(8'h5A);
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0802) begin
            bad++; $display("FAIL full_pp_status: got %h, required 00000802", rd);
        end
        drain_and_check("full_pp");
        // Empty FIFO with tx_ready=1: push still lands, count becomes 1.
        write_word(A_TXDATA, 32'h0000_0077);
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0100 || tx_data !== 8'h77) begin
            bad++; $display("FAIL empty_pp: status=%h data=%h, required 00000100/77", rd, tx_data);
        end
        step();
        total++;
        if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL empty_pp_drain: valid=%b, required 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] exp_c [3];
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        exp_c[0] = 32'hFFFF_FFFE;
        exp_c[1] = 32'hFFFF_FFFF;
        exp_c[2] = 32'h0000_0000;
`else
        exp_c[0] = 32'h0;
        exp_c[1] = 32'h0;
        exp_c[2] = 32'h0;
`endif
        write_word(A_CYCLE, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            read_word(A_CYCLE, rd);
            total++;
            if (rd !== exp_c[i]) begin
                bad++; $display("FAIL counter_%0d: got %h, required %h", i, rd, exp_c[i]);
            end
            @(posedge clk);
            #0;
        end
    endtask

    task automatic test_reset_mid_drain();
        step();
        write_word(32'h0000_0020, 32'hCAFE_F00D);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        tx_ready = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++; $display("FAIL rst_async_valid: got %b, required 0", tx_valid);
        end
        read_word(A_STATUS, rd);
        total++;
        if (rd !== 32'h0000_0004) begin
            bad++; $display("FAIL rst_async_status: got %h, required 00000004", rd);
        end
        step();
        reset = 1'b0;
        read_word(A_CYCLE, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL rst_cycle: got %h, required 00000000", rd);
        end
        read_word(32'h0000_0020, rd);
        total++;
        if (rd !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rst_ram_keep: got %h, required cafef00d", rd);
        end
        read_word(32'h0000_0010, rd);
        total++;
        if (rd !== 32'h1234_5678) begin
            bad++; $display("FAIL rst_ram_keep2: got %h, required 12345678", rd);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tx_valid !== 1'b0) begin
                bad++; $display("FAIL rst_no_valid_%0d: got %b, required 0", i, tx_valid);
            end
        end
        tx_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_ram();
        test_fifo_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_counter();
        test_reset_mid_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
